// File: rtl/antilog2_pkg.sv
// Shared log-domain definitions: log2 word format, antilog state encoding and
// the 2^(2^-k) constant table used by the shift-and-multiply antilog.
package antilog2_pkg;

  localparam int LOG_INT_W  = 5;
  localparam int LOG_FRAC_W = 27;
  localparam int LOG_W      = LOG_INT_W + LOG_FRAC_W;
  localparam int FRAC_USED  = 16;
  localparam int FRAC_DROP  = LOG_FRAC_W - FRAC_USED;
  localparam int OUT_W      = 32;
  localparam int MANT_W     = 32;
  localparam int CNT_W      = 4;

  localparam logic [MANT_W-1:0] MANT_ONE = 32'h8000_0000;
  localparam logic [OUT_W-1:0]  MAG_SAT  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    OUT
  } state_e;

  // Latched operand: integer part plus the fraction bits still to be consumed.
  typedef struct packed {
    logic                 sign;
    logic                 zero;
    logic [LOG_INT_W-1:0] int_part;
    logic [FRAC_USED-1:0] frac;
  } operand_t;

  // C[k] = 2^(2^-k) in Q1.31, rounded to nearest; entry i holds k = i + 1.
  localparam logic [MANT_W-1:0] POW2_FRAC_C [FRAC_USED] = '{
    32'hB504_F334, 32'h9837_F052, 32'h8B95_C1E4, 32'h85AA_C368,
    32'h82CD_8699, 32'h8164_D1F4, 32'h80B1_ED50, 32'h8058_D7D3,
    32'h802C_6437, 32'h8016_302F, 32'h800B_179D, 32'h8005_8BAF,
    32'h8002_C5D0, 32'h8001_62E6, 32'h8000_B173, 32'h8000_58B9
  };

  // Q1.31 mantissa in [1,2) scaled by 2^int into Q16.16 (int <= 15 only).
  function automatic logic [OUT_W-1:0] scale_mant(input logic [MANT_W-1:0] mant,
                                                  input logic [3:0]        int_lo);
    logic [3:0] sh;
    sh = 4'd15 - int_lo;
    return mant >> sh;
  endfunction

endpackage

// File: rtl/antilog2_pow2_frac_rom.sv
// Combinational lookup of C[k] = 2^(2^-k); idx 0..15 selects k = 1..16.
module pow2_frac_rom
  import antilog2_pkg::*;
(
  input  logic [CNT_W-1:0]  idx,
  output logic [MANT_W-1:0] c_k
);

  always_comb begin
    c_k = POW2_FRAC_C[idx];
  end

endmodule

// File: rtl/antilog2.sv
// Log2 -> linear converter: 2^(int.frac) via 16 conditional constant multiplies
// on a Q1.31 mantissa, then a shift by the integer part into Q16.16.
module antilog2
  import antilog2_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic             in_zero,
  input  logic [LOG_W-1:0] in_log,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [OUT_W-1:0] out_mag,
  output logic             out_sat
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MANT_W-1:0]   mant_q, mant_d;
  operand_t            op_q, op_d;
  logic                out_valid_q, out_valid_d;
  logic                out_sign_q, out_sign_d;
  logic                out_sat_q, out_sat_d;
  logic [OUT_W-1:0]    out_mag_q, out_mag_d;

  logic [MANT_W-1:0]   c_k;
  logic [2*MANT_W-1:0] prod;
  logic                unused_bits;

  pow2_frac_rom u_rom (
    .idx (cnt_q),
    .c_k (c_k)
  );

  // Q1.31 x Q1.31 = Q2.62; the result stays below 2.0, so bits [62:31] are Q1.31.
  assign prod        = {{MANT_W{1'b0}}, mant_q} * {{MANT_W{1'b0}}, c_k};
  assign unused_bits = ^{prod[2*MANT_W-1], prod[MANT_W-2:0], in_log[FRAC_DROP-1:0]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mant_d      = mant_q;
    op_d        = op_q;
    out_valid_d = out_valid_q;
    out_sign_d  = out_sign_q;
    out_sat_d   = out_sat_q;
    out_mag_d   = out_mag_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d          = ITER;
          cnt_d            = '0;
          mant_d           = MANT_ONE;
          op_d.sign        = in_sign;
          op_d.zero        = in_zero;
          op_d.int_part    = in_log[LOG_W-1:LOG_FRAC_W];
          op_d.frac        = in_log[LOG_FRAC_W-1:FRAC_DROP];
        end
      end

      ITER: begin
        // Fraction is consumed MSB first, so frac[MSB] is always bit -(cnt+1).
        if (op_q.frac[FRAC_USED-1]) begin
          mant_d = prod[2*MANT_W-2:MANT_W-1];
        end
        op_d.frac = {op_q.frac[FRAC_USED-2:0], 1'b0};
        cnt_d     = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = OUT;
        end
      end

      OUT: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_sign_d  = op_q.sign;
          if (op_q.zero) begin
            out_mag_d = '0;
            out_sat_d = 1'b0;
          end else if (op_q.int_part[LOG_INT_W-1]) begin
            out_mag_d = MAG_SAT;
            out_sat_d = 1'b1;
          end else begin
            out_mag_d = scale_mant(mant_q, op_q.int_part[3:0]);
            out_sat_d = 1'b0;
          end
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mant_q      <= MANT_ONE;
      op_q        <= '0;
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_sat_q   <= 1'b0;
      out_mag_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mant_q      <= mant_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      out_sign_q  <= out_sign_d;
      out_sat_q   <= out_sat_d;
      out_mag_q   <= out_mag_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_sign  = out_sign_q;
  assign out_sat   = out_sat_q;
  assign out_mag   = out_mag_q;

endmodule

// File: tb/tb_antilog2.sv
// Scoreboard bench for antilog2: stimulus pushes expected results, a negedge
// monitor pops and compares on every accepted output.
module tb_antilog2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic        in_zero = 1'b0;
  logic [31:0] in_log = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sign;
  logic [31:0] out_mag;
  logic        out_sat;

  antilog2 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_zero   (in_zero),
    .in_log    (in_log),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_mag   (out_mag),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] mag;
    logic        sat;
    logic        sign;
    int          tol;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req, input int tol);
    longint d;
    total++;
    d = longint'(act) - longint'(req);
    if (d < 0) d = -d;
    if (d > longint'(tol)) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (tol %0d)", name, act, req, tol);
    end
  endtask

  // Monitor: latency on the rising edge of out_valid, data on each transfer.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got out_valid=1 expected no result pending");
        end else begin
          check({"lat_", sb[0].name}, 32'(cyc - sb[0].acc), 32'd17, 0);
        end
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check({"mag_", e.name}, out_mag, e.mag, e.tol);
        check({"sat_", e.name}, {31'b0, out_sat}, {31'b0, e.sat}, 0);
        check({"sign_", e.name}, {31'b0, out_sign}, {31'b0, e.sign}, 0);
        $display("[tb] %s mag=0x%08h sat=%0b sign=%0b", e.name, out_mag, out_sat, out_sign);
      end
    end
    prev_valid <= rst ? 1'b0 : out_valid;
  end

  task automatic send(input string name, input logic sign, input logic zero,
                      input logic [31:0] lg, input logic [31:0] em, input logic es,
                      input int tol, input bit push);
    int   n;
    exp_t e;
    n = 0;
    @(posedge clk); #1;
    while (!in_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL ready_timeout_%s: got in_ready=0 expected 1 within 60 cycles", name);
      return;
    end
    in_valid = 1'b1;
    in_sign  = sign;
    in_zero  = zero;
    in_log   = lg;
    if (push) begin
      e.name = name; e.mag = em; e.sat = es; e.sign = sign; e.tol = tol; e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_zero  = 1'b0;
    in_sign  = 1'b0;
    in_log   = 32'hDEAD_BEEF;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", 32'(sb.size()), 32'd0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [4:0]  ip;
    logic [26:0] fr;
    logic [31:0] lg, em;
    real         x;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  {31'b0, in_ready},  32'd1, 0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0, 0);
    check("rst_out_mag",   out_mag,            32'd0, 0);
    check("rst_out_sat",   {31'b0, out_sat},   32'd0, 0);
    check("rst_out_sign",  {31'b0, out_sign},  32'd0, 0);

    // Directed vectors, expectations worked by hand.
    send("log0",     1'b0, 1'b0, 32'h0000_0000, 32'h0001_0000, 1'b0, 0, 1'b1);
    send("log3neg",  1'b1, 1'b0, 32'h1800_0000, 32'h0008_0000, 1'b0, 0, 1'b1);
    send("log0p5",   1'b0, 1'b0, 32'h0400_0000, 32'h0001_6A09, 1'b0, 1, 1'b1);
    send("log0p25",  1'b0, 1'b0, 32'h0200_0000, 32'h0001_306F, 1'b0, 1, 1'b1);
    send("log1",     1'b0, 1'b0, 32'h0800_0000, 32'h0002_0000, 1'b0, 0, 1'b1);
    send("log15",    1'b0, 1'b0, 32'h7800_0000, 32'h8000_0000, 1'b0, 0, 1'b1);
    send("log15max", 1'b0, 1'b0, 32'h7FFF_FFFF, 32'hFFFF_4E8D, 1'b0, 40, 1'b1);
    send("log16",    1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b1);
    send("log31",    1'b1, 1'b0, 32'hF800_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b1);
    send("zero",     1'b1, 1'b1, 32'h1234_5678, 32'h0000_0000, 1'b0, 0, 1'b1);
    send("zerobig",  1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 0, 1'b1);
    drain(60);

    // Backpressure: hold out_ready low for 10 cycles once the result appears.
    out_ready = 1'b0;
    send("stall", 1'b1, 1'b0, 32'h0800_0000, 32'h0002_0000, 1'b0, 0, 1'b1);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("stall_seen", {31'b0, out_valid}, 32'd1, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", {31'b0, out_valid}, 32'd1, 0);
      check("stall_mag",   out_mag,            32'h0002_0000, 0);
      check("stall_sign",  {31'b0, out_sign},  32'd1, 0);
      check("stall_ready", {31'b0, in_ready},  32'd0, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("single_xfer_valid", {31'b0, out_valid}, 32'd0, 0);
    check("single_xfer_ready", {31'b0, in_ready},  32'd1, 0);
    drain(10);

    // Reset during ITER step 8: the result must never appear.
    send("abort", 1'b0, 1'b0, 32'h1234_0000, 32'h0, 1'b0, 0, 1'b0);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready",  {31'b0, in_ready},  32'd1, 0);
    check("abort_out_valid", {31'b0, out_valid}, 32'd0, 0);
    n = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("abort_no_valid", 32'(n), 32'd0, 0);
    send("post_abort", 1'b0, 1'b0, 32'h0000_0000, 32'h0001_0000, 1'b0, 0, 1'b1);
    drain(40);

    // Sweep against a real-valued model of the 16 retained fraction bits.
    for (int i = 0; i < 20; i++) begin
      ip = 5'($urandom_range(0, 9));
      fr = 27'($urandom);
      lg = {ip, fr};
      x  = real'(ip) + real'(fr[26:11]) / 65536.0;
      em = 32'($rtoi((2.0 ** x) * 65536.0));
      send($sformatf("sweep%0d", i), 1'($urandom_range(0, 1)), 1'b0, lg, em, 1'b0, 2, 1'b1);
    end
    drain(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
